// File: rtl/vital_arbiter_if.sv
// vital_arbiter_if: request/load/status bundle between behaviour controllers and the vital counter arbiter.
interface vital_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req_inc;
   logic [N_REQ-1:0] req_dec;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] value;
   logic [1:0]       indicator;
   logic [N_REQ-1:0] grant;
   logic             at_max;
   logic             at_min;
   modport master (
      output req_inc, req_dec, load_en, load_val,
      input  value, indicator, grant, at_max, at_min
   );
   modport slave (
      input  req_inc, req_dec, load_en, load_val,
      output value, indicator, grant, at_max, at_min
   );
endinterface

// File: rtl/vital_arbiter.sv
// vital_arbiter: round-robin arbiter granting one inc/dec per update slot to a shared saturating counter.
module vital_arbiter #(
   parameter int WIDTH    = 8,
   parameter int N_REQ    = 4,
   parameter int STEP     = 4,
   parameter int TICK_DIV = 16,
   parameter int INIT     = 128
) (
   input logic clk,
   input logic rst_n,
   vital_arbiter_if.slave bus
);
   localparam int PW    = $clog2(TICK_DIV);
   localparam int PTR_W = $clog2(N_REQ);
   logic [PW-1:0]    presc;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] g;
   logic             hit;
   logic             slot;
   logic [WIDTH-1:0] value_q;
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] active;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;
   logic [WIDTH-1:0] upd_val;
   logic [PTR_W-1:0] ptr_nxt;
   assign slot    = presc == PW'(TICK_DIV - 1);
   assign active  = bus.req_inc ^ bus.req_dec;
   assign sum     = {1'b0, value_q} + (WIDTH+1)'(STEP);
   assign inc_val = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
   assign dec_val = value_q < WIDTH'(STEP) ? '0 : value_q - WIDTH'(STEP);
   assign upd_val = bus.req_inc[g] ? inc_val : dec_val;
   assign ptr_nxt = g == PTR_W'(N_REQ - 1) ? '0 : g + 1'b1;
   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      hit = 1'b0;
      g   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (active[(int'(ptr) + k) % N_REQ]) begin
            hit = 1'b1;
            g   = PTR_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         ptr     <= '0;
         value_q <= WIDTH'(INIT);
         grant_q <= '0;
      end else begin
         presc   <= slot ? '0 : presc + 1'b1;
         grant_q <= '0;
         if (bus.load_en) begin
            value_q <= bus.load_val;
         end else if (slot && hit) begin
            grant_q <= N_REQ'(1) << g;
            value_q <= upd_val;
            ptr     <= ptr_nxt;
         end
      end
   end
   assign bus.value     = value_q;
   assign bus.indicator = value_q[WIDTH-1:WIDTH-2];
   assign bus.grant     = grant_q;
   assign bus.at_max    = value_q == '1;
   assign bus.at_min    = value_q == '0;
endmodule

// File: tb/tb_vital_arbiter.sv
// tb_vital_arbiter: directed scenarios for vital_arbiter with TICK_DIV=4, STEP=4, INIT=128.
module tb_vital_arbiter;
   localparam int WIDTH = 8;
   localparam int N_REQ = 4;
   localparam int STEP = 4;
   localparam int TICK_DIV = 4;
   localparam int INIT = 128;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   int ph = 0;
   vital_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();
   vital_arbiter #(
      .WIDTH(WIDTH), .N_REQ(N_REQ), .STEP(STEP), .TICK_DIV(TICK_DIV), .INIT(INIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
      ph++;
   endtask
   // Steps until the edge that closes an update slot has just passed.
   task automatic next_slot();
      do step(); while (ph % TICK_DIV != 0);
   endtask
   task automatic do_reset();
      bus.req_inc = '0;
      bus.req_dec = '0;
      bus.load_en = 1'b0;
      bus.load_val = '0;
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      ph = 0;
   endtask
   task automatic test_reset();
      do_reset();
      checks++; if (bus.value !== 8'h80) begin failures++; $display("FAIL reset_value got=%h exp=80", bus.value); end
      checks++; if (bus.indicator !== 2'b10) begin failures++; $display("FAIL reset_ind got=%b exp=10", bus.indicator); end
      checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
      checks++; if ({bus.at_max, bus.at_min} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {bus.at_max, bus.at_min}); end
      bus.load_en = 1'b1;
      bus.load_val = 8'h10;
      step();
      bus.load_en = 1'b0;
      checks++; if (bus.value !== 8'h10) begin failures++; $display("FAIL load_pre got=%h exp=10", bus.value); end
      bus.req_inc = 4'b0010;
      while (ph % TICK_DIV != TICK_DIV - 1) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.value !== 8'h80) begin failures++; $display("FAIL midslot_value got=%h exp=80", bus.value); end
      checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL midslot_grant got=%b exp=0000", bus.grant); end
      checks++; if (bus.indicator !== 2'b10) begin failures++; $display("FAIL midslot_ind got=%b exp=10", bus.indicator); end
      @(posedge clk);
      #1;
      checks++; if (bus.value !== 8'h80) begin failures++; $display("FAIL held_reset_value got=%h exp=80", bus.value); end
   endtask
   task automatic test_inc_sat();
      logic [8:0] exp;
      do_reset();
      bus.req_inc = 4'b0010;
      exp = 9'd128;
      for (int k = 1; k <= 34; k++) begin
         step();
         checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL inc_gap_grant k=%0d got=%b exp=0000", k, bus.grant); end
         next_slot();
         exp = (exp + 9'd4 > 9'd255) ? 9'd255 : exp + 9'd4;
         checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL inc_grant k=%0d got=%b exp=0010", k, bus.grant); end
         checks++; if (bus.value !== exp[7:0]) begin failures++; $display("FAIL inc_value k=%0d got=%h exp=%h", k, bus.value, exp[7:0]); end
         checks++; if (bus.at_max !== (exp == 9'd255)) begin failures++; $display("FAIL inc_at_max k=%0d got=%b exp=%b", k, bus.at_max, exp == 9'd255); end
      end
      checks++; if (bus.indicator !== 2'b11) begin failures++; $display("FAIL sat_ind got=%b exp=11", bus.indicator); end
   endtask
   task automatic test_round_robin();
      logic [3:0] eg [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0] ev [4] = '{8'd124, 8'd128, 8'd124, 8'd120};
      do_reset();
      bus.req_dec = 4'b1001;
      bus.req_inc = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         next_slot();
         checks++; if (bus.grant !== eg[k]) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, bus.grant, eg[k]); end
         checks++; if (bus.value !== ev[k]) begin failures++; $display("FAIL rr_value k=%0d got=%0d exp=%0d", k, bus.value, ev[k]); end
      end
   endtask
   task automatic test_cancel();
      do_reset();
      bus.req_inc = 4'b0010;
      bus.req_dec = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         next_slot();
         checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL cancel_grant k=%0d got=%b exp=0000", k, bus.grant); end
         checks++; if (bus.value !== 8'h80) begin failures++; $display("FAIL cancel_value k=%0d got=%h exp=80", k, bus.value); end
      end
   endtask
   task automatic test_min();
      do_reset();
      bus.load_en = 1'b1;
      bus.load_val = 8'd2;
      step();
      bus.load_en = 1'b0;
      bus.req_dec = 4'b0001;
      next_slot();
      checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL min_grant got=%b exp=0001", bus.grant); end
      checks++; if (bus.value !== 8'd0) begin failures++; $display("FAIL min_value got=%0d exp=0", bus.value); end
      checks++; if (bus.at_min !== 1'b1) begin failures++; $display("FAIL min_flag got=%b exp=1", bus.at_min); end
      checks++; if (bus.indicator !== 2'b00) begin failures++; $display("FAIL min_ind got=%b exp=00", bus.indicator); end
      next_slot();
      checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL min2_grant got=%b exp=0001", bus.grant); end
      checks++; if (bus.value !== 8'd0) begin failures++; $display("FAIL min2_value got=%0d exp=0", bus.value); end
   endtask
   task automatic test_load_slot();
      do_reset();
      bus.req_inc = 4'b0011;
      while (ph % TICK_DIV != TICK_DIV - 1) step();
      bus.load_en = 1'b1;
      bus.load_val = 8'hC5;
      step();
      bus.load_en = 1'b0;
      checks++; if (bus.value !== 8'hC5) begin failures++; $display("FAIL load_value got=%h exp=c5", bus.value); end
      checks++; if (bus.indicator !== 2'b11) begin failures++; $display("FAIL load_ind got=%b exp=11", bus.indicator); end
      checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL load_grant got=%b exp=0000", bus.grant); end
      next_slot();
      checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL post_load_grant got=%b exp=0001", bus.grant); end
      checks++; if (bus.value !== 8'hC9) begin failures++; $display("FAIL post_load_value got=%h exp=c9", bus.value); end
   endtask
   initial begin
      test_reset();
      test_inc_sat();
      test_round_robin();
      test_cancel();
      test_min();
      test_load_slot();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
